nmos_phase_gen: RTL and testbench
=================================

NMOS_PHASE_GEN -- requirements
Module: nmos_phase_gen

Interface
REQ-001 Parameter PHI_LEN, default 4, main_clk cycles per active phase (legal range 1..255).
REQ-002 Parameter GAP_LEN, default 1, non-overlap cycles after each phase (legal range 0..255).
REQ-003 Parameter CNT_W, default 16, width of the completed-cycle counter.
REQ-004 Port main_clk  input  1  sole clock.
REQ-005 Port main_rst  input  1  synchronous, active-high reset.
REQ-006 Port run  input  1  level; free-running two-phase generation while high.
REQ-007 Port step  input  1  single-cycle request; one full PHI1/PHI2 cycle from idle.
REQ-008 Port C1  output  1  PHI1 qualifier for downstream NMOS cells.
REQ-009 Port C2  output  1  PHI2 qualifier for downstream NMOS cells.
REQ-010 Port C1_end  output  1  high during the last cycle of each PHI1 phase.
REQ-011 Port C2_end  output  1  high during the last cycle of each PHI2 phase.
REQ-012 Port cyc_cnt  output  CNT_W  count of completed PHI1+PHI2 cycles.
REQ-013 Port halted  output  1  high while in IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, PH1, G1, PH2 and G2, with all outputs registered.
REQ-015 IDLE SHALL go to PH1 on the edge where run=1 or step=1 is sampled; C1 SHALL be high from the following cycle.
REQ-016 PH1 SHALL last exactly PHI_LEN cycles with C1=1, followed by G1.
REQ-017 G1 SHALL last GAP_LEN cycles with C1=C2=0, followed by PH2; G1 SHALL be skipped when GAP_LEN=0.
REQ-018 PH2 SHALL last exactly PHI_LEN cycles with C2=1, followed by G2 (skipped when GAP_LEN=0).
REQ-019 At the end of G2 (or of PH2 when GAP_LEN=0), cyc_cnt SHALL increment by 1, modulo 2^CNT_W; the next state SHALL be PH1 if run=1 is sampled on that edge, otherwise IDLE.
REQ-020 C1 and C2 SHALL never both be 1 in any cycle, including when GAP_LEN=0.
REQ-021 C1_end/C2_end SHALL be high only in the final cycle of PH1/PH2; with PHI_LEN=1 they SHALL coincide with the single active cycle.
REQ-022 Deasserting run mid-cycle SHALL never truncate a phase; the current cycle SHALL complete, then the block SHALL enter IDLE.
REQ-023 step SHALL be ignored outside IDLE; when run and step are both high in IDLE, run SHALL take effect (free-running).
REQ-024 halted SHALL be 1 exactly when the state is IDLE.
REQ-025 The steady free-running period SHALL be 2*(PHI_LEN+GAP_LEN) cycles.

Reset
REQ-026 With main_rst=1 sampled: state=IDLE, C1=C2=0, C1_end=C2_end=0, cyc_cnt=0, halted=1, phase counter=0.
REQ-027 Reset SHALL override run and step and SHALL take effect on the next edge from any state, including mid-phase.
REQ-028 In the first cycle after reset release, run=1 SHALL start PH1 per REQ-015.

Structure
REQ-029 The state encoding localparams (IDLE..G2) SHALL live in the shared package nmos_clk_pkg, for reuse by other clock-domain helpers.
REQ-030 A single down-counter, 8 bits wide and reloaded at each state entry, SHALL time all phases; no sub-module is required.

Verification (PHI_LEN=4, GAP_LEN=1 unless stated)
REQ-031 Reset, then run held high for 30 cycles -> repeating C1 for 4 cycles, 1 gap, C2 for 4 cycles, 1 gap; period 10; cyc_cnt reads 1, 2, 3 at each G2 exit; C1&C2 never both high.
REQ-032 A 1-cycle step pulse in IDLE -> exactly one 10-cycle sequence, then halted=1 and cyc_cnt 0->1; a second step issued during PH2 is ignored.
REQ-033 run dropped in the 2nd cycle of PH2 -> PH2 completes (4 cycles), then G2 (1 cycle), then IDLE; cyc_cnt incremented once.
REQ-034 main_rst asserted in the 3rd cycle of PH1 -> C1=0 and cyc_cnt=0 on the next edge; halted=1.
REQ-035 GAP_LEN=0, PHI_LEN=1, run high -> C1 and C2 alternate every cycle, never overlapping; C1_end=C1 and C2_end=C2.
REQ-036 CNT_W=4, run held for 16 cycles of the sequence -> cyc_cnt wraps 15->0.

Source files
------------

// File: rtl/nmos_clk_pkg.sv
// nmos_clk_pkg: shared state encoding and timer helpers for two-phase clock generators
package nmos_clk_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH1 = 3'd1;
  localparam logic [2:0] ST_G1 = 3'd2;
  localparam logic [2:0] ST_PH2 = 3'd3;
  localparam logic [2:0] ST_G2 = 3'd4;
  localparam int TMR_W = 8;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PH1 = ST_PH1,
    G1 = ST_G1,
    PH2 = ST_PH2,
    G2 = ST_G2
  } state_e;
  function automatic logic [TMR_W-1:0] reload(input int len);
    return len == 0 ? '0 : TMR_W'(len - 1);
  endfunction
endpackage

// File: rtl/nmos_phase_gen.sv
// nmos_phase_gen: non-overlapping PHI1/PHI2 qualifier generator (run/step control, cycle counter)
module nmos_phase_gen
  import nmos_clk_pkg::*;
#(
  parameter int PHI_LEN = 4,
  parameter int GAP_LEN = 1,
  parameter int CNT_W = 16
) (
  input  logic             main_clk,
  input  logic             main_rst,
  input  logic             run,
  input  logic             step,
  output logic             C1,
  output logic             C2,
  output logic             C1_end,
  output logic             C2_end,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             halted
);
  localparam logic [TMR_W-1:0] PH_RLD = reload(PHI_LEN);
  localparam logic [TMR_W-1:0] GAP_RLD = reload(GAP_LEN);
  state_e state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic c1_q, c1_d, c2_q, c2_d, c1e_q, c1e_d, c2e_q, c2e_d, halted_q, halted_d;
  logic done, wrap;
  always_comb begin
    done = tmr_q == '0;
    wrap = done && (state_q == G2 || (state_q == PH2 && GAP_LEN == 0));
    state_d = state_q;
    tmr_d = done ? '0 : tmr_q - 1'b1;
    cnt_d = wrap ? cnt_q + 1'b1 : cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = (run || step) ? PH1 : IDLE;
        tmr_d = (run || step) ? PH_RLD : '0;
      end
      PH1: if (done) begin
        state_d = GAP_LEN > 0 ? G1 : PH2;
        tmr_d = GAP_LEN > 0 ? GAP_RLD : PH_RLD;
      end
      G1: if (done) begin
        state_d = PH2;
        tmr_d = PH_RLD;
      end
      PH2: if (done && GAP_LEN > 0) begin
        state_d = G2;
        tmr_d = GAP_RLD;
      end
      default: state_d = state_q;
    endcase
    if (wrap) begin
      state_d = run ? PH1 : IDLE;
      tmr_d = run ? PH_RLD : '0;
    end
    c1_d = state_d == PH1;
    c2_d = state_d == PH2;
    c1e_d = c1_d && tmr_d == '0;
    c2e_d = c2_d && tmr_d == '0;
    halted_d = state_d == IDLE;
  end
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      cnt_q <= '0;
      c1_q <= 1'b0;
      c2_q <= 1'b0;
      c1e_q <= 1'b0;
      c2e_q <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      cnt_q <= cnt_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      c1e_q <= c1e_d;
      c2e_q <= c2e_d;
      halted_q <= halted_d;
    end
  end
  assign C1 = c1_q;
  assign C2 = c2_q;
  assign C1_end = c1e_q;
  assign C2_end = c2e_q;
  assign cyc_cnt = cnt_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_nmos_phase_gen.sv
// tb_nmos_phase_gen: scoreboard bench for nmos_phase_gen in three parameterisations
module tb_nmos_phase_gen;
  typedef struct packed {
    logic c1, c2, e1, e2, h;
    logic [15:0] cnt;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1, run0 = 1'b0, step0 = 1'b0, run1 = 1'b0, run2 = 1'b0;
  logic c1_0, c2_0, e1_0, e2_0, h_0, c1_1, c2_1, e1_1, e2_1, h_1, c1_2, c2_2, e1_2, e2_2, h_2;
  logic [15:0] cnt_0, cnt_1;
  logic [3:0] cnt_2;
  obs_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  nmos_phase_gen d0 (.main_clk(clk), .main_rst(rst), .run(run0), .step(step0), .C1(c1_0), .C2(c2_0),
    .C1_end(e1_0), .C2_end(e2_0), .cyc_cnt(cnt_0), .halted(h_0));
  nmos_phase_gen #(.PHI_LEN(1), .GAP_LEN(0)) d1 (.main_clk(clk), .main_rst(rst), .run(run1), .step(1'b0),
    .C1(c1_1), .C2(c2_1), .C1_end(e1_1), .C2_end(e2_1), .cyc_cnt(cnt_1), .halted(h_1));
  nmos_phase_gen #(.CNT_W(4)) d2 (.main_clk(clk), .main_rst(rst), .run(run2), .step(1'b0),
    .C1(c1_2), .C2(c2_2), .C1_end(e1_2), .C2_end(e2_2), .cyc_cnt(cnt_2), .halted(h_2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic obs_t pat(input int k, input int base, input int phi, input int gap, input int cw);
    obs_t o;
    int per, p;
    per = 2 * (phi + gap);
    p = k % per;
    o.c1 = p < phi;
    o.e1 = p == phi - 1;
    o.c2 = p >= phi + gap && p < 2 * phi + gap;
    o.e2 = p == 2 * phi + gap - 1;
    o.h = 1'b0;
    o.cnt = 16'((base + k / per) % (1 << cw));
    return o;
  endfunction
  function automatic obs_t idle_o(input int cnt);
    obs_t o;
    o = '0;
    o.h = 1'b1;
    o.cnt = 16'(cnt);
    return o;
  endfunction
  function automatic obs_t get(input int d);
    obs_t o;
    o = d == 0 ? {c1_0, c2_0, e1_0, e2_0, h_0, cnt_0} :
        d == 1 ? {c1_1, c2_1, e1_1, e2_1, h_1, cnt_1} :
                 {c1_2, c2_2, e1_2, e2_2, h_2, 12'b0, cnt_2};
    return o;
  endfunction
  task automatic check(input string tag, input obs_t o);
    obs_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
      return;
    end
    e = sb.pop_front();
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed c1=%b c2=%b e1=%b e2=%b halted=%b cnt=%0d expected c1=%b c2=%b e1=%b e2=%b halted=%b cnt=%0d",
        tag, o.c1, o.c2, o.e1, o.e2, o.h, o.cnt, e.c1, e.c2, e.e1, e.e2, e.h, e.cnt);
    end
    checks++;
    assert (!(o.c1 && o.c2)) else begin
      errors++;
      $error("FAIL %s_overlap: observed C1=%b C2=%b expected not both 1", tag, o.c1, o.c2);
    end
  endtask
  initial begin
    sb.push_back(idle_o(0));
    tick();
    check("reset", get(0));
    rst = 1'b0;
    sb.push_back(idle_o(0));
    tick();
    check("idle", get(0));
    run0 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      sb.push_back(pat(k, 0, 4, 1, 16));
      tick();
      check("run", get(0));
    end
    run0 = 1'b0;
    sb.push_back(idle_o(3));
    tick();
    check("run_stop", get(0));
    step0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back(pat(k, 3, 4, 1, 16));
      tick();
      check("step", get(0));
      step0 = k == 5;
    end
    step0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(idle_o(4));
      tick();
      check("step_done", get(0));
    end
    run0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back(pat(k, 4, 4, 1, 16));
      tick();
      check("drop", get(0));
      if (k == 6) run0 = 1'b0;
    end
    sb.push_back(idle_o(5));
    tick();
    check("drop_idle", get(0));
    run0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(pat(k, 5, 4, 1, 16));
      tick();
      check("pre_rst", get(0));
    end
    rst = 1'b1;
    sb.push_back(idle_o(0));
    tick();
    check("mid_rst", get(0));
    rst = 1'b0;
    run0 = 1'b0;
    run1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back(pat(k, 0, 1, 0, 16));
      tick();
      check("nogap", get(1));
    end
    run1 = 1'b0;
    sb.push_back(idle_o(5));
    tick();
    check("nogap_idle", get(1));
    run2 = 1'b1;
    for (int k = 0; k <= 160; k++) begin
      sb.push_back(pat(k, 0, 4, 1, 4));
      tick();
      check("wrap", get(2));
    end
    run2 = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
